jtag_seq: RTL

Synthesizable JTAG shift sequencer that accepts batched TMS/TDI bit vectors over a valid/ready command interface and drives the JTAG pins with a programmable TCK half-period. Captured TDO bits are returned over a valid/ready response interface. It sits between an on-chip debug requester, or a socket-to-bus bridge, and the TAP pins. It is the hardware counterpart of the DPI pin driver, reusing the same half-period notion: one TCK phase equals HALF_PERIOD clk_i ticks.

---
 rtl/jtag_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_seq.sv
// jtag_seq: JTAG shift sequencer.
// Accepts one batched TMS/TDI command at a time over a valid/ready interface.
// It shifts the bits out on the TAP pins with a TCK half-period of HALF_PERIOD clk_i ticks.
// The captured TDO bits are returned over a valid/ready response interface.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_rst_i                     TAP reset command (5 x TMS=1, TRST asserted)
//   cmd_len_i, cmd_tms_i, cmd_tdi_i  bit count and vectors, bit 0 first
//   resp_valid_o / resp_ready_i   response handshake
//   resp_tdo_o                    captured TDO, bit i from command bit i
//   busy_o                        sequencer not idle
//   tck_o, tms_o, tdi_o, trst_o   JTAG pins (trst_o active-low)
//   tdo_i                         JTAG TDO, already synchronous to clk_i
module jtag_seq #(
    parameter int MAX_BITS    = 32,
    parameter int HALF_PERIOD = 8,
    parameter int LW          = $clog2(MAX_BITS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_rst_i,
    input  logic [LW-1:0]       cmd_len_i,
    input  logic [MAX_BITS-1:0] cmd_tms_i,
    input  logic [MAX_BITS-1:0] cmd_tdi_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [MAX_BITS-1:0] resp_tdo_o,
    output logic                busy_o,
    output logic                tck_o,
    output logic                tms_o,
    output logic                tdi_o,
    output logic                trst_o,
    input  logic                tdo_i
);
    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    // Bit counters must also hold the fixed 5-bit reset sequence.
    localparam int CW = (LW > 3) ? LW : 3;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [CW-1:0]       bit_q, bit_d;
    logic [CW-1:0]       len_q, len_d;
    logic                rst_cmd_q, rst_cmd_d;
    logic [MAX_BITS-1:0] tms_sr_q, tms_sr_d;
    logic [MAX_BITS-1:0] tdi_sr_q, tdi_sr_d;
    logic [MAX_BITS-1:0] tdo_q, tdo_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                trst_q, trst_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       len_eff;
    logic                phase_end;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        len_d     = len_q;
        rst_cmd_d = rst_cmd_q;
        tms_sr_d  = tms_sr_q;
        tdi_sr_d  = tdi_sr_q;
        tdo_d     = tdo_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        trst_d    = trst_q;

        if (cmd_rst_i)
            len_eff = CW'(5);
        else if (CW'(cmd_len_i) > CW'(MAX_BITS))
            len_eff = CW'(MAX_BITS);
        else
            len_eff = CW'(cmd_len_i);

        phase_end = (phase_q == PW'(HALF_PERIOD - 1));

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d   = LOW;
                    phase_d   = '0;
                    bit_d     = '0;
                    len_d     = len_eff;
                    rst_cmd_d = cmd_rst_i;
                    tdo_d     = '0;
                    if (cmd_rst_i) begin
                        trst_d = 1'b0;
                        tms_d  = 1'b1;
                        tdi_d  = 1'b0;
                    end else if (len_eff != '0) begin
                        // Bit 0 goes on the pins now; the rest wait in the shifters.
                        tms_d    = cmd_tms_i[0];
                        tdi_d    = cmd_tdi_i[0];
                        tms_sr_d = cmd_tms_i >> 1;
                        tdi_sr_d = cmd_tdi_i >> 1;
                    end
                end
            end
            LOW: begin
                // A zero-length command passes through LOW for one cycle, no TCK edge.
                if (len_q == '0) begin
                    state_d = RESP;
                end else if (phase_end) begin
                    state_d = HIGH;
                    phase_d = '0;
                    tck_d   = 1'b1;
                    if (!rst_cmd_q) begin
                        for (int i = 0; i < MAX_BITS; i++)
                            if (CW'(i) == bit_q) tdo_d[i] = tdo_i;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            HIGH: begin
                if (phase_end) begin
                    phase_d = '0;
                    tck_d   = 1'b0;
                    if (bit_q == len_q - CW'(1)) begin
                        state_d = RESP;
                        trst_d  = 1'b1;
                    end else begin
                        state_d = LOW;
                        bit_d   = bit_q + CW'(1);
                        // Reset commands keep TMS=1/TDI=0 for every bit.
                        if (!rst_cmd_q) begin
                            tms_d    = tms_sr_q[0];
                            tdi_d    = tdi_sr_q[0];
                            tms_sr_d = tms_sr_q >> 1;
                            tdi_sr_d = tdi_sr_q >> 1;
                        end
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            rst_cmd_q <= 1'b0;
            tms_sr_q  <= '0;
            tdi_sr_q  <= '0;
            tdo_q     <= '0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            trst_q    <= 1'b1;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            rst_cmd_q <= rst_cmd_d;
            tms_sr_q  <= tms_sr_d;
            tdi_sr_q  <= tdi_sr_d;
            tdo_q     <= tdo_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            trst_q    <= trst_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_tdo_o   = tdo_q;
    assign busy_o       = busy_q;
    assign tck_o        = tck_q;
    assign tms_o        = tms_q;
    assign tdi_o        = tdi_q;
    assign trst_o       = trst_q;

endmodule
